// File: rtl/vbsme_port_arbiter_pkg.sv
// Shared definitions for the VBSME shared-port arbiter: FSM encoding, owner
// codes (identical to the external 2-to-1 mux select) and the owner picker.
package vbsme_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int ADDR_STEP_DEFAULT = 4;

    // A lone requester wins outright; on a tie the one not served last wins.
    function automatic logic pick_owner(input logic req_a, input logic req_b,
                                        input logic last_served);
        logic owner;
        if (req_a && req_b) begin
            owner = ~last_served;
        end else if (req_b) begin
            owner = OWNER_B;
        end else begin
            owner = OWNER_A;
        end
        return owner;
    endfunction

endpackage

// File: rtl/vbsme_burst_counter.sv
// Beat counter, latched burst base/length and the beat address adder for the
// shared port. The address wraps modulo 2^ADDR_W without any indication.
module vbsme_burst_counter #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(ADDR_STEP);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [ADDR_W-1:0] beat_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else if (load) begin
            base_q <= base_in;
            len_q  <= len_in;
            beat_q <= '0;
        end else if (advance && !last) begin
            // The counter parks on the final beat once the burst completes.
            beat_q <= beat_q + LEN_W'(1);
        end
    end

    assign last     = (beat_q == len_q);
    assign beat_ext = ADDR_W'(beat_q);
    assign addr_out = base_q + (beat_ext * STEP_V);

endmodule

// File: rtl/vbsme_port_arbiter.sv
// Round-robin burst arbiter sharing one 32-bit address/data port between the
// current-block loader (A) and the search-window loader (B).
module vbsme_port_arbiter
    import vbsme_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [LEN_W-1:0]  len_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              req_b,
    input  logic [LEN_W-1:0]  len_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              ready,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic              valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              done_a,
    output logic              done_b,
    output state_t            state_dbg
);

    // Handshake: a beat transfers on a rising edge where valid && ready.
    // valid is decoded from registered state only; ready low holds the beat.

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   grant_pick;
    logic   load;
    logic   advance;
    logic   last_beat;

    logic [LEN_W-1:0]  len_sel;
    logic [ADDR_W-1:0] base_sel;

    assign grant_pick = pick_owner(req_a, req_b, last_q);
    assign len_sel    = (grant_pick == OWNER_B) ? len_b  : len_a;
    assign base_sel   = (grant_pick == OWNER_B) ? addr_b : addr_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_A;
            // Pretending B was served last makes the first tie go to A.
            last_q  <= OWNER_B;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    state_d = ST_BUSY;
                    owner_d = grant_pick;
                    load    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (ready) begin
                    advance = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    vbsme_burst_counter #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_burst_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .advance  (advance),
        .len_in   (len_sel),
        .base_in  (base_sel),
        .addr_out (addr_out),
        .last     (last_beat)
    );

    // owner_q only changes on a grant, so the mux select holds between bursts.
    assign sel       = owner_q;
    assign valid     = (state_q == ST_BUSY);
    assign gnt_a     = valid && (owner_q == OWNER_A);
    assign gnt_b     = valid && (owner_q == OWNER_B);
    assign done_a    = (state_q == ST_DONE) && (owner_q == OWNER_A);
    assign done_b    = (state_q == ST_DONE) && (owner_q == OWNER_B);
    assign state_dbg = state_q;

endmodule

// File: doc/vbsme_port_arbiter.md
# vbsme_port_arbiter

- Round-robin arbiter that shares one 32-bit data/address path between two requesters in the VBSME datapath, e.g. the current-block loader (A) and the search-window loader (B).
- Drives the select of the existing 32-bit 2-to-1 mux and generates the burst addresses for the shared port.
- Grants whole bursts, never single beats, so a requester's sequential word fetch is never interleaved with the other's.

## Interface
Parameters:
- ADDR_W, 32, address width
- LEN_W, 4, burst-length field width; a burst is Len+1 beats (1..16)
- ADDR_STEP, 4, byte increment per beat (word-addressed memory, byte addresses)

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- ReqA  in  1  requester A wants a burst; held until its Done
- LenA  in  LEN_W  A burst length minus one; sampled at grant
- AddrA  in  ADDR_W  A burst base byte address; sampled at grant
- ReqB, LenB, AddrB  in  1/LEN_W/ADDR_W  same for requester B
- Ready  in  1  shared port accepts the current beat
- GntA  out  1  A owns the port (BUSY with owner A)
- GntB  out  1  B owns the port
- Sel  out  1  mux select: 0 = A, 1 = B
- Valid  out  1  AddrOut carries a beat
- AddrOut  out  ADDR_W  current beat byte address
- DoneA  out  1  one-cycle pulse: A's burst finished
- DoneB  out  1  one-cycle pulse: B's burst finished

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when ReqA or ReqB is high.
  - Owner: the sole requester, or on a tie the one not served last.
  - Priority pointer resets to favour A.
  - Latches owner, Len and base address; beat counter = 0.
- BUSY:
  - Gnt(owner) = 1, Sel = owner, Valid = 1.
  - AddrOut = base + ADDR_STEP × beat, computed modulo 2^ADDR_W; address wrap past 0xFFFFFFFC is allowed and silent.
  - On each Valid && Ready, the beat counter increments.
  - On the handshake of beat == Len → DONE.
  - Ready low stalls: address and counter hold.
- DONE (one cycle):
  - Gnt low, Valid low, Done(owner) = 1.
  - Pointer records owner as last served.
  - → IDLE.
- Req deassertion mid-burst is ignored; the burst runs to completion. Req is not sampled in BUSY or DONE.
- Sel holds its last value outside BUSY; it never toggles while Valid = 1.
- Len/Addr inputs changing after grant have no effect.

## Timing
- Reset values: state IDLE, GntA = GntB = 0, Sel = 0, Valid = 0, AddrOut = 0, DoneA = DoneB = 0, pointer favours A.
- Reset mid-burst aborts immediately with no Done pulse.
- All outputs are registered or decoded from registered state only; there is no combinational path from Ready/Req to outputs.
- Req high at edge N: Gnt and Valid high from cycle N+1 with AddrOut = base.
- Latency of a burst with Ready held high: Len+1 BUSY cycles, then one DONE cycle, then one IDLE cycle.
- Minimum re-grant gap: 2 cycles (DONE + IDLE) between the last beat of one burst and the first beat of the next.
- Simultaneous ReqA and ReqB in IDLE: exactly one grant, per the pointer. With both held continuously, grants strictly alternate A, B, A, B.

## Structure
- Shared package: state encoding constants (IDLE/BUSY/DONE), OWNER_A = 0 / OWNER_B = 1 constants (shared with the mux select), and the ADDR_STEP default.
- One natural sub-module: `vbsme_burst_counter`, which holds the beat counter, the base-address register and the AddrOut adder, with load/advance/last outputs.
- The FSM and round-robin pointer stay in the top module.
- The existing 32-bit 2-to-1 mux is instantiated by the parent, not inside this block.

## Test plan
- Reset with ReqA = 1: all outputs 0. Release Rst_n → GntA and Valid high one cycle later, AddrOut = AddrA.
- ReqA only, LenA = 3, AddrA = 0x100, Ready = 1 → AddrOut 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles, then DoneA pulse, Sel = 0 throughout.
- ReqA and ReqB both held, LenA = LenB = 0 → grants alternate A, B, A, B starting with A after reset, with 2 idle cycles between beats; Sel tracks 0, 1, 0, 1.
- ReqB, LenB = 2, Ready toggling 1,0,0,1,1 → three handshakes only; AddrOut holds during stalls; DoneB pulses once after the third handshake.
- AddrA = 0xFFFFFFF8, LenA = 2 → AddrOut 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Rst_n asserted during beat 2 of a 5-beat burst → outputs 0 at once, no Done pulse. After release, a fresh ReqB with ReqA idle is granted normally.
